// File: rtl/ddr_out_reg.sv
// ddr_out_reg: behavioural output DDR register.
// Each lane takes two single-rate bits per clock (D1, D2) and drives them
// onto Q as one stream that changes on both clock edges: D1 while C is high,
// D2 while C is low. R (clear) and S (set) act immediately, R winning.
module ddr_out_reg #(
    parameter string       DDR_CLK_EDGE = "OPPOSITE_EDGE",
    parameter logic        INIT         = 1'b0,
    parameter int unsigned WIDTH        = 1
) (
    input  logic             C,
    input  logic             R,
    input  logic             S,
    input  logic             CE,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    output logic [WIDTH-1:0] Q
);

    // SAME_EDGE captures both bits on the rising edge; OPPOSITE_EDGE takes
    // D2 on the falling edge instead.
    localparam bit SAME_EDGE_MODE = (DDR_CLK_EDGE == "SAME_EDGE");

    // Any other mode string cannot be built meaningfully, so stop elaboration.
    if ((DDR_CLK_EDGE != "SAME_EDGE") && (DDR_CLK_EDGE != "OPPOSITE_EDGE")) begin : g_bad_edge
        $fatal(1, "ddr_out_reg: DDR_CLK_EDGE must be SAME_EDGE or OPPOSITE_EDGE");
    end

    // Power-up contents come from INIT; R/S override at any time afterwards.
    logic [WIDTH-1:0] r1_q = {WIDTH{INIT}};
    logic [WIDTH-1:0] r2_q = {WIDTH{INIT}};
    logic [WIDTH-1:0] q_q  = {WIDTH{INIT}};

    logic [WIDTH-1:0] r1_d;
    logic [WIDTH-1:0] r2_d;
    logic [WIDTH-1:0] q_rise_d;
    logic [WIDTH-1:0] q_fall_d;

    // Capture-flop next state: load on CE, otherwise hold.
    always_comb begin
        r1_d = r1_q;
        r2_d = r2_q;
        if (CE) begin
            r1_d = D1;
            r2_d = D2;
        end else begin
            r1_d = r1_q;
            r2_d = r2_q;
        end
    end

    // Values Q takes at each clock edge. With CE low the held capture flops
    // keep being replayed, so Q still alternates r1/r2 every half period.
    // In SAME_EDGE the low-half value is the D2 taken at the preceding
    // rising edge (the falling-edge copy of r2 lives in Q itself); in
    // OPPOSITE_EDGE it is D2 sampled right at the falling edge.
    always_comb begin
        q_rise_d = r1_d;
        q_fall_d = r2_q;
        if (SAME_EDGE_MODE) begin
            q_fall_d = r2_q;
        end else begin
            q_fall_d = r2_d;
        end
    end

    // First-phase capture flop: rising edge, async clear/set.
    always_ff @(posedge C or posedge R or posedge S) begin
        if (R) begin
            r1_q <= '0;
        end else if (S) begin
            r1_q <= '1;
        end else begin
            r1_q <= r1_d;
        end
    end

    // Second-phase capture flop: its clock edge depends on the capture mode.
    if (SAME_EDGE_MODE) begin : g_same_edge
        // D2 captured alongside D1 on the rising edge.
        always_ff @(posedge C or posedge R or posedge S) begin
            if (R) begin
                r2_q <= '0;
            end else if (S) begin
                r2_q <= '1;
            end else begin
                r2_q <= r2_d;
            end
        end
    end else begin : g_opposite_edge
        // D2 captured on the falling edge.
        always_ff @(negedge C or posedge R or posedge S) begin
            if (R) begin
                r2_q <= '0;
            end else if (S) begin
                r2_q <= '1;
            end else begin
                r2_q <= r2_d;
            end
        end
    end

    // Output register updated on both clock edges, so Q only ever changes
    // at an edge (or on R/S) and never glitches between edges.
    always_ff @(posedge C or negedge C or posedge R or posedge S) begin
        if (R) begin
            q_q <= '0;
        end else if (S) begin
            q_q <= '1;
        end else if (C) begin
            q_q <= q_rise_d;
        end else begin
            q_q <= q_fall_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_ddr_out_reg.sv
// tb_ddr_out_reg: table-driven check of ddr_out_reg in both capture modes
// (12 lanes each) plus a 1-lane INIT=1 instance, with hand-written sequences
// for reset, set/priority and the opposite-edge D2 sampling point.
module tb_ddr_out_reg;

    logic        clk = 1'b0;
    logic        r   = 1'b0;
    logic        s   = 1'b0;
    logic        ce  = 1'b1;
    logic [11:0] d1  = 12'h000;
    logic [11:0] d2  = 12'h000;
    logic [11:0] q_same;
    logic [11:0] q_opp;
    logic [0:0]  q_init;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    typedef struct {
        logic        ce;
        logic [11:0] d1;
        logic [11:0] d2;
        logic [11:0] exp_hi;
        logic [11:0] exp_lo;
    } vec_t;

    vec_t vecs [10];

    ddr_out_reg #(.DDR_CLK_EDGE("SAME_EDGE"), .INIT(1'b0), .WIDTH(12)) u_same (
        .C(clk), .R(r), .S(s), .CE(ce), .D1(d1), .D2(d2), .Q(q_same)
    );

    ddr_out_reg #(.DDR_CLK_EDGE("OPPOSITE_EDGE"), .INIT(1'b0), .WIDTH(12)) u_opp (
        .C(clk), .R(r), .S(s), .CE(ce), .D1(d1), .D2(d2), .Q(q_opp)
    );

    ddr_out_reg #(.DDR_CLK_EDGE("OPPOSITE_EDGE"), .INIT(1'b1), .WIDTH(1)) u_init (
        .C(clk), .R(r), .S(s), .CE(ce), .D1(d1[0:0]), .D2(d2[0:0]), .Q(q_init)
    );

    // Clock: first rising edge at t=10, period 20.
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %03h expected %03h", name, act, exp);
        end
    endtask

    // Watchdog: the bench never waits on DUT events, but bound the run anyway.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 12'hABC, 12'h123, 12'hABC, 12'h123};
        vecs[1] = '{1'b1, 12'hFFF, 12'h000, 12'hFFF, 12'h000};
        vecs[2] = '{1'b1, 12'h000, 12'hFFF, 12'h000, 12'hFFF};
        vecs[3] = '{1'b1, 12'h555, 12'hAAA, 12'h555, 12'hAAA};
        vecs[4] = '{1'b1, 12'hA5A, 12'h3C3, 12'hA5A, 12'h3C3};
        vecs[5] = '{1'b1, 12'hFFF, 12'h000, 12'hFFF, 12'h000};
        vecs[6] = '{1'b0, 12'h000, 12'hFFF, 12'hFFF, 12'h000};
        vecs[7] = '{1'b0, 12'h123, 12'h456, 12'hFFF, 12'h000};
        vecs[8] = '{1'b0, 12'hABC, 12'hABC, 12'hFFF, 12'h000};
        vecs[9] = '{1'b1, 12'h0F0, 12'hF0F, 12'h0F0, 12'hF0F};

        // Power-up values before any clock edge.
        #1;
        chk("init1_q_time0", {11'b0, q_init}, 12'h001);
        chk("same_q_time0", q_same, 12'h000);
        chk("opp_q_time0", q_opp, 12'h000);
        @(posedge clk); #2;
        chk("init1_q_after_edge", {11'b0, q_init}, 12'h000);

        // Table: inputs driven in the low phase, Q sampled mid-high and mid-low.
        @(negedge clk); #3;
        for (int i = 0; i < 10; i++) begin
            ce = vecs[i].ce;
            d1 = vecs[i].d1;
            d2 = vecs[i].d2;
            @(posedge clk); #2;
            chk($sformatf("vec%0d_same_hi", i), q_same, vecs[i].exp_hi);
            chk($sformatf("vec%0d_opp_hi", i), q_opp, vecs[i].exp_hi);
            @(negedge clk); #2;
            chk($sformatf("vec%0d_same_lo", i), q_same, vecs[i].exp_lo);
            chk($sformatf("vec%0d_opp_lo", i), q_opp, vecs[i].exp_lo);
            #1;
        end

        // Reset pulse in the high phase with all-ones data.
        ce = 1'b1; d1 = 12'hFFF; d2 = 12'hFFF;
        @(posedge clk); #2;
        chk("rst_pre_same", q_same, 12'hFFF);
        #1 r = 1'b1;
        #1;
        chk("rst_imm_same", q_same, 12'h000);
        chk("rst_imm_opp", q_opp, 12'h000);
        @(negedge clk); #2;
        chk("rst_held_same", q_same, 12'h000);
        chk("rst_held_opp", q_opp, 12'h000);
        #1 r = 1'b0;
        #2;
        chk("rst_rel_same", q_same, 12'h000);
        chk("rst_rel_opp", q_opp, 12'h000);
        @(posedge clk); #2;
        chk("rst_resume_same_hi", q_same, 12'hFFF);
        chk("rst_resume_opp_hi", q_opp, 12'hFFF);
        @(negedge clk); #2;
        chk("rst_resume_same_lo", q_same, 12'hFFF);
        chk("rst_resume_opp_lo", q_opp, 12'hFFF);
        #1;

        // D2 changes between the rising and falling edges.
        d1 = 12'h000; d2 = 12'h000;
        @(posedge clk); #2;
        chk("late_d2_same_hi", q_same, 12'h000);
        chk("late_d2_opp_hi", q_opp, 12'h000);
        #1 d2 = 12'hFFF;
        @(negedge clk); #2;
        chk("late_d2_same_lo", q_same, 12'h000);
        chk("late_d2_opp_lo", q_opp, 12'hFFF);
        @(posedge clk); #2;
        chk("late_d2_same_hi2", q_same, 12'h000);
        @(negedge clk); #2;
        chk("late_d2_same_lo2", q_same, 12'hFFF);
        chk("late_d2_opp_lo2", q_opp, 12'hFFF);
        #1;

        // Asynchronous set, then reset overriding set.
        d1 = 12'h000; d2 = 12'hFFF;
        @(posedge clk); #2;
        chk("set_pre_opp", q_opp, 12'h000);
        #1 s = 1'b1;
        #1;
        chk("set_same", q_same, 12'hFFF);
        chk("set_opp", q_opp, 12'hFFF);
        chk("set_init1", {11'b0, q_init}, 12'h001);
        #1 r = 1'b1;
        #1;
        chk("rs_prio_same", q_same, 12'h000);
        chk("rs_prio_opp", q_opp, 12'h000);
        chk("rs_prio_init1", {11'b0, q_init}, 12'h000);
        #1 s = 1'b0;
        #1 r = 1'b0;
        #1;
        chk("rs_rel_same", q_same, 12'h000);
        @(negedge clk); #2;
        chk("rs_resume_same_lo", q_same, 12'h000);
        chk("rs_resume_opp_lo", q_opp, 12'hFFF);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
